// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 32x32 register file: one holding slot per source,
// round-robin grant onto the single registered write port, plus a RAW pending mask.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic                       Reg_Write_En,
  output logic [ADDR_W-1:0]          Result_Addr,
  output logic [DATA_W-1:0]          Result_to_Register,
  output logic [2**ADDR_W-1:0]       pending_mask
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] occ;
  logic [ADDR_W-1:0]  slot_addr [NUM_REQ];
  logic [DATA_W-1:0]  slot_data [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic               grant_valid;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] hazard;
  logic [NUM_REQ-1:0] accept;
  int                 scan_pos;

  // First occupied slot at or after rr_ptr, wrapping around the requesters.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_pos    = 0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_pos = int'(rr_ptr) + k;
      if (scan_pos >= NUM_REQ) begin
        scan_pos = scan_pos - NUM_REQ;
      end
      scan_idx = PTR_W'(scan_pos);
      if (!grant_valid && occ[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_valid && (grant_idx == PTR_W'(i));
    end
  end

  // A request waits while an older write to the same register is still queued
  // behind the port, or a lower-index source targets it in the same cycle.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_addr[i*ADDR_W +: ADDR_W] != '0) begin
          if ((j != i) && occ[j] && !grant_oh[j] &&
              (slot_addr[j] == req_addr[i*ADDR_W +: ADDR_W])) begin
            hazard[i] = 1'b1;
          end
          if ((j < i) && req_valid[j] &&
              (req_addr[j*ADDR_W +: ADDR_W] == req_addr[i*ADDR_W +: ADDR_W])) begin
            hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset && !flush && !hazard[i] && (!occ[i] || grant_oh[i]);
    end
    accept = req_valid & req_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Reg_Write_En       <= 1'b0;
      Result_Addr        <= '0;
      Result_to_Register <= '0;
      rr_ptr             <= '0;
    end else if (flush) begin
      Reg_Write_En <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant_valid) begin
      Reg_Write_En       <= 1'b1;
      Result_Addr        <= slot_addr[grant_idx];
      Result_to_Register <= slot_data[grant_idx];
      rr_ptr             <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end else begin
      Reg_Write_En <= 1'b0;
    end
  end

  // A slot may refill in the same cycle it is granted; x0 writes are consumed
  // but never marked occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          occ[i]       <= (req_addr[i*ADDR_W +: ADDR_W] != '0);
          slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (grant_oh[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (occ[i]) begin
        pending_mask[slot_addr[i]] = 1'b1;
      end
    end
    if (Reg_Write_En) begin
      pending_mask[Result_Addr] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a falling-edge register file model
// and hand-computed expected write sequences.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        Reg_Write_En;
  logic [4:0]  Result_Addr;
  logic [31:0] Result_to_Register;
  logic [31:0] pending_mask;

  bit [31:0] regs [32];
  int        wr_count;
  int        checks;
  int        fails;
  int        wr_before;
  int        seq [3];
  logic [2:0] rdy;

  logic [4:0]  rr_exp_addr [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
  logic [31:0] rr_exp_data [7] = '{32'h0, 32'h11110000, 32'h22220000, 32'h33330000,
                                   32'h11110001, 32'h22220001, 32'h33330001};
  logic [31:0] rr_base [3] = '{32'h11110000, 32'h22220000, 32'h33330000};

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .Reg_Write_En       (Reg_Write_En),
    .Result_Addr        (Result_Addr),
    .Result_to_Register (Result_to_Register),
    .pending_mask       (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: samples the write port on the falling edge.
  always @(negedge clk) begin
    if (Reg_Write_En) begin
      regs[Result_Addr] = Result_to_Register;
      wr_count++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]         = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearReqs();
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic flushOnce();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    wr_count = 0;
    reset    = 1'b0;
    flush    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_en", 64'(Reg_Write_En), 64'd0);
    checkOutput("rst_mask", 64'(pending_mask), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready", 64'(req_ready), 64'h7);
    tick();

    // Single source write of x5
    $display("[TB] single source");
    applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checkOutput("single_ready", 64'(req_ready[0]), 64'd1);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_en_k", 64'(Reg_Write_En), 64'd0);
    checkOutput("single_mask_k", 64'(pending_mask), 64'h20);
    tick();
    checkOutput("single_en_k1", 64'(Reg_Write_En), 64'd1);
    checkOutput("single_addr", 64'(Result_Addr), 64'd5);
    checkOutput("single_data", 64'(Result_to_Register), 64'hDEADBEEF);
    checkOutput("single_mask_k1", 64'(pending_mask), 64'h20);
    tick();
    checkOutput("single_en_k2", 64'(Reg_Write_En), 64'd0);
    checkOutput("single_mask_k2", 64'(pending_mask), 64'd0);
    checkOutput("single_rf_x5", 64'(regs[5]), 64'hDEADBEEF);

    // Round-robin with all three sources held valid
    $display("[TB] round robin");
    flushOnce();
    for (int i = 0; i < 3; i++) begin
      seq[i] = 0;
      applyStimulus(i, 1'b1, 5'(i + 1), rr_base[i]);
    end
    for (int n = 0; n < 7; n++) begin
      #1;
      rdy = req_ready & req_valid;
      tick();
      for (int i = 0; i < 3; i++) begin
        if (rdy[i]) begin
          seq[i]++;
          applyStimulus(i, 1'b1, 5'(i + 1), rr_base[i] + 32'(seq[i]));
        end
      end
      checkOutput("rr_en", 64'(Reg_Write_En), 64'(n != 0));
      if (n > 0) begin
        checkOutput("rr_addr", 64'(Result_Addr), 64'(rr_exp_addr[n]));
        checkOutput("rr_data", 64'(Result_to_Register), 64'(rr_exp_data[n]));
      end
    end
    clearReqs();
    flushOnce();

    // Same-address ordering, same-cycle tie
    $display("[TB] same address");
    applyStimulus(0, 1'b1, 5'd7, 32'h70);
    applyStimulus(2, 1'b1, 5'd7, 32'h72);
    #1;
    checkOutput("tie_ready0", 64'(req_ready[0]), 64'd1);
    checkOutput("tie_ready2", 64'(req_ready[2]), 64'd0);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("tie_en_e1", 64'(Reg_Write_En), 64'd0);
    checkOutput("tie_mask_e1", 64'(pending_mask), 64'h80);
    checkOutput("tie_ready2_e1", 64'(req_ready[2]), 64'd1);
    tick();
    applyStimulus(2, 1'b0, 5'd0, 32'h0);
    checkOutput("tie_addr_e2", 64'(Result_Addr), 64'd7);
    checkOutput("tie_data_e2", 64'(Result_to_Register), 64'h70);
    tick();
    checkOutput("tie_en_e3", 64'(Reg_Write_En), 64'd1);
    checkOutput("tie_data_e3", 64'(Result_to_Register), 64'h72);
    @(negedge clk);
    #1;
    checkOutput("tie_rf_x7", 64'(regs[7]), 64'h72);

    // Same-address ordering against a pending, not granted slot
    applyStimulus(1, 1'b1, 5'd4, 32'h44);
    tick();
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    checkOutput("pend_en_f1", 64'(Reg_Write_En), 64'd0);
    applyStimulus(0, 1'b1, 5'd7, 32'h71);
    applyStimulus(2, 1'b1, 5'd9, 32'h99);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    applyStimulus(2, 1'b0, 5'd0, 32'h0);
    checkOutput("pend_addr_f2", 64'(Result_Addr), 64'd4);
    checkOutput("pend_data_f2", 64'(Result_to_Register), 64'h44);
    applyStimulus(1, 1'b1, 5'd7, 32'h7B);
    #1;
    checkOutput("pend_ready1_f2", 64'(req_ready[1]), 64'd0);
    tick();
    checkOutput("pend_addr_f3", 64'(Result_Addr), 64'd9);
    checkOutput("pend_data_f3", 64'(Result_to_Register), 64'h99);
    checkOutput("pend_ready1_f3", 64'(req_ready[1]), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    checkOutput("pend_addr_f4", 64'(Result_Addr), 64'd7);
    checkOutput("pend_data_f4", 64'(Result_to_Register), 64'h71);
    tick();
    checkOutput("pend_en_f5", 64'(Reg_Write_En), 64'd1);
    checkOutput("pend_data_f5", 64'(Result_to_Register), 64'h7B);
    @(negedge clk);
    #1;
    checkOutput("pend_rf_x7", 64'(regs[7]), 64'h7B);
    tick();

    // x0 write is consumed and dropped
    $display("[TB] x0 discard");
    wr_before = wr_count;
    applyStimulus(1, 1'b1, 5'd0, 32'h1234);
    #1;
    checkOutput("x0_ready", 64'(req_ready[1]), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_en1", 64'(Reg_Write_En), 64'd0);
    checkOutput("x0_mask", 64'(pending_mask), 64'd0);
    tick();
    checkOutput("x0_en2", 64'(Reg_Write_En), 64'd0);
    tick();
    checkOutput("x0_writes", 64'(wr_count - wr_before), 64'd0);
    checkOutput("x0_rf", 64'(regs[0]), 64'd0);

    // Flush with all slots full
    $display("[TB] flush");
    applyStimulus(0, 1'b1, 5'd10, 32'hA0);
    applyStimulus(1, 1'b1, 5'd11, 32'hA1);
    applyStimulus(2, 1'b1, 5'd12, 32'hA2);
    #1;
    checkOutput("fl_ready_fill", 64'(req_ready), 64'h7);
    tick();
    applyStimulus(0, 1'b1, 5'd13, 32'hB0);
    applyStimulus(1, 1'b1, 5'd14, 32'hB1);
    applyStimulus(2, 1'b1, 5'd15, 32'hB2);
    flush = 1'b1;
    wr_before = wr_count;
    #1;
    checkOutput("fl_ready_flush", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    clearReqs();
    checkOutput("fl_en", 64'(Reg_Write_En), 64'd0);
    checkOutput("fl_mask", 64'(pending_mask), 64'd0);
    tick();
    tick();
    checkOutput("fl_writes", 64'(wr_count - wr_before), 64'd0);
    checkOutput("fl_rf_x10", 64'(regs[10]), 64'd0);
    applyStimulus(0, 1'b1, 5'd16, 32'hC0);
    applyStimulus(1, 1'b1, 5'd17, 32'hC1);
    applyStimulus(2, 1'b1, 5'd18, 32'hC2);
    tick();
    clearReqs();
    tick();
    checkOutput("fl_rr_addr0", 64'(Result_Addr), 64'd16);
    checkOutput("fl_rr_data0", 64'(Result_to_Register), 64'hC0);
    tick();
    checkOutput("fl_rr_addr1", 64'(Result_Addr), 64'd17);
    tick();
    checkOutput("fl_rr_addr2", 64'(Result_Addr), 64'd18);
    tick();
    checkOutput("fl_rf_x18", 64'(regs[18]), 64'hC2);

    // Asynchronous reset mid-traffic with all slots full
    $display("[TB] async reset");
    applyStimulus(0, 1'b1, 5'd20, 32'hD0);
    applyStimulus(1, 1'b1, 5'd21, 32'hD1);
    applyStimulus(2, 1'b1, 5'd22, 32'hD2);
    tick();
    #2;
    reset = 1'b0;
    wr_before = wr_count;
    #1;
    checkOutput("ar_en", 64'(Reg_Write_En), 64'd0);
    checkOutput("ar_mask", 64'(pending_mask), 64'd0);
    checkOutput("ar_ready", 64'(req_ready), 64'd0);
    clearReqs();
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 1'b1, 5'd25, 32'h25);
    tick();
    applyStimulus(0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("ar_first_en", 64'(Reg_Write_En), 64'd1);
    checkOutput("ar_first_addr", 64'(Result_Addr), 64'd25);
    tick();
    tick();
    checkOutput("ar_writes", 64'(wr_count - wr_before), 64'd1);
    checkOutput("ar_rf_x20", 64'(regs[20]), 64'd0);
    checkOutput("ar_rf_x22", 64'(regs[22]), 64'd0);
    checkOutput("ar_rf_x25", 64'(regs[25]), 64'h25);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file. It shares the single write port (`Reg_Write_En` / `Result_Addr` / `Result_to_Register`) among NUM_REQ write-back sources (ALU, load unit, CSR/mul), using one holding slot per source and round-robin grant. It preserves per-address write order and suppresses writes to x0. It also exports a pending-write mask that decode uses for RAW stalls.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous discard of all held and incoming requests
- req_valid  in  NUM_REQ  per-source write request
- req_ready  out  NUM_REQ  per-source accept; transfer on valid & ready at rising edge
- req_addr  in  NUM_REQ*ADDR_W  destination register; source i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data, packed the same way
- Reg_Write_En  out  1  registered write enable to the register file
- Result_Addr  out  ADDR_W  registered write address
- Result_to_Register  out  DATA_W  registered write data
- pending_mask  out  2**ADDR_W  bit a = 1 while a write to register a is held or on the output

## Operation
- State: per-source slot (occ, addr, data); output register (Reg_Write_En, Result_Addr, Result_to_Register); round-robin pointer rr_ptr.
- Grant (combinational): the first occupied slot scanning from rr_ptr upward, wrapping modulo NUM_REQ. At most one grant per cycle.
- On each rising edge with a grant g:
  - Output register loads {1, slot g addr, slot g data}.
  - occ[g] clears.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- On a rising edge with no grant: Reg_Write_En loads 0. Addr and data hold their previous values. rr_ptr holds.
- Ready: req_ready[i] = (!occ[i] | grant==i) & !flush & !hazard[i].
- hazard[i] is 1 when req_addr[i] equals the addr of any slot j≠i that is occupied and not granted this cycle. It is also 1 when req_addr[i] equals req_addr[j] for some j<i with req_valid[j]. On a tie, the lower index wins. This keeps writes to the same register in acceptance order.
- Accept: on valid & ready, the slot loads addr and data, and occ is set unless addr==0.
  - An x0 request is consumed with ready=1 and never written.
  - x0 requests are exempt from hazard checks.
- flush=1 at an edge:
  - All occ clear and no accepts occur (req_ready=0 during flush).
  - Reg_Write_En loads 0.
  - rr_ptr resets to 0.
  - A write already on the output at that edge still completes at that cycle's falling edge.
- pending_mask: the OR of the one-hot decodes of every occupied slot addr, plus Result_Addr when Reg_Write_En=1. Bit 0 is always 0.
- Asynchronous reset (reset=0), effective immediately and held while low:
  - occ=0, rr_ptr=0.
  - Reg_Write_En=0, Result_Addr=0, Result_to_Register=0.
  - req_ready=0, pending_mask=0.

## Timing
- The register file samples on the falling edge of clk. Outputs are registered on the rising edge and are stable across the following falling edge.
- Latency: a request accepted at rising edge k can be granted at edge k+1, at the earliest. It is then driven on the write port during cycle k+1..k+2 and written at that cycle's falling edge.
- Throughput: one register write per cycle aggregate. A single source can sustain one accepted request per cycle, because a slot may refill in the same cycle it is granted.
- Under contention with all slots full and all valids held, each source is granted once every NUM_REQ cycles (starvation-free).
- Reset deassertion: the first accept can occur at the first rising edge after reset rises.

## Test plan
- Reset: drive reset=0 mid-traffic with all slots full. Required: Reg_Write_En=0, pending_mask=0, and req_ready=0 immediately. After release, the previously held writes never appear.
- Single source: src0 writes x5=0xDEADBEEF at edge k. Required: at edge k+1, Reg_Write_En=1, Result_Addr=5, Result_to_Register=0xDEADBEEF. Register file x5 reads 0xDEADBEEF after that falling edge. pending_mask[5] is 1 for 2 cycles.
- Round-robin: 3 sources held valid continuously to x1/x2/x3 with changing data. Required: grant order 0,1,2,0,1,2; exactly one write per cycle.
- Same-address order:
  - src2 and src0 both request x7 in the same cycle. Required: src0 accepted first and src2 stalled (ready=0) until src0's slot drains. x7 ends with src2's data.
  - Repeat with src1 arriving while src0's x7 slot is pending and not granted. Required: src1 stalled.
- x0 discard: src1 writes x0=0x1234. Required: ready=1, no Reg_Write_En pulse, pending_mask unchanged, x0 reads 0.
- Flush: fill all slots, then assert flush for 1 cycle. Required: no further writes, all req_ready=0 during flush, rr_ptr=0 afterwards, and the next accepted request is written normally.
